complex_integer_divider_unit: RTL and testbench

Iterative radix-2 integer divider for the complex integer execution stage. It accepts one divide/remainder micro-op at a time and runs a restoring division loop over DATA_WIDTH cycles. It then holds the result until the downstream register-write stage acknowledges it. The operation is discarded when the recovery logic flushes it.

---
 rtl/complex_integer_divider_unit.sv | 173 +++++++++++++++++
 tb/tb_complex_integer_divider_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_integer_divider_unit.sv
// complex_integer_divider_unit: iterative radix-2 restoring divider
// for the complex integer execution stage.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   reqValid/Ready  issue handshake for one DIV/DIVU/REM/REMU op
//   reqIsSigned     signed op (DIV/REM) vs unsigned (DIVU/REMU)
//   reqIsRem        return remainder instead of quotient
//   dividend        operand A
//   divisor         operand B
//   reqAlPtr        active-list pointer carried with the op
//   flush           kill the in-flight op
//   busy            unit holds an op
//   finished        result valid, held until ack
//   result          sign-corrected quotient or remainder
//   resAlPtr        active-list pointer of the finished op
//   ack             consumer takes the result this cycle
module complex_integer_divider_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int AL_PTR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqIsSigned,
  input  logic                    reqIsRem,
  input  logic [DATA_WIDTH-1:0]   dividend,
  input  logic [DATA_WIDTH-1:0]   divisor,
  input  logic [AL_PTR_WIDTH-1:0] reqAlPtr,
  input  logic                    flush,
  output logic                    busy,
  output logic                    finished,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [AL_PTR_WIDTH-1:0] resAlPtr,
  input  logic                    ack
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   quo_q, quo_d;
  logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    is_rem_q, is_rem_d;
  logic                    neg_q, neg_d;
  logic [AL_PTR_WIDTH-1:0] al_q, al_d;

  logic                    accept;
  logic                    a_neg, b_neg;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag;
  logic                    is_zero, is_ovf;
  logic [DATA_WIDTH:0]     rem_sh;
  logic [DATA_WIDTH-1:0]   diff;
  logic                    q_bit;
  logic [DATA_WIDTH-1:0]   rem_next, quo_next;
  logic [DATA_WIDTH-1:0]   sel, sel_fix;

  assign reqReady = (state_q == IDLE) ||
                    (state_q == DONE && ack);
  assign accept   = reqValid && reqReady && !flush;
  assign busy     = (state_q != IDLE);
  assign finished = (state_q == DONE);
  assign result   = result_q;
  assign resAlPtr = al_q;

  always_comb begin
    a_neg   = reqIsSigned && dividend[DATA_WIDTH-1];
    b_neg   = reqIsSigned && divisor[DATA_WIDTH-1];
    a_mag   = a_neg ? -dividend : dividend;
    b_mag   = b_neg ? -divisor : divisor;
    is_zero = (divisor == '0);
    is_ovf  = reqIsSigned && (dividend == MIN) &&
              (divisor == '1);

    // Quotient register doubles as the dividend shifter:
    // its MSB feeds the partial remainder each step.
    rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
    q_bit    = (rem_sh >= {1'b0, dvs_q});
    // When q_bit is set the difference is below the
    // divisor, so DATA_WIDTH bits hold it exactly.
    diff     = rem_sh[DATA_WIDTH-1:0] - dvs_q;
    rem_next = q_bit ? diff : rem_sh[DATA_WIDTH-1:0];
    quo_next = {quo_q[DATA_WIDTH-2:0], q_bit};
    sel      = is_rem_q ? rem_next : quo_next;
    sel_fix  = neg_q ? -sel : sel;

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    is_rem_d = is_rem_q;
    neg_d    = neg_q;
    al_d     = al_q;

    unique case (state_q)
      IDLE: ;
      CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = sel_fix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      is_rem_d = reqIsRem;
      neg_d    = reqIsRem ? a_neg : (a_neg ^ b_neg);
      al_d     = reqAlPtr;
      cnt_d    = CNT_INIT;
      rem_d    = '0;
      quo_d    = a_mag;
      dvs_d    = b_mag;
      if (is_zero) begin
        state_d  = DONE;
        result_d = reqIsRem ? dividend : '1;
      end else if (is_ovf) begin
        state_d  = DONE;
        result_d = reqIsRem ? '0 : MIN;
      end else begin
        state_d = CALC;
      end
    end

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
      al_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      is_rem_q <= is_rem_d;
      neg_q    <= neg_d;
      al_q     <= al_d;
    end
  end

endmodule

// File: tb/tb_complex_integer_divider_unit.sv
// tb_complex_integer_divider_unit: directed checks of the
// iterative divider (latency, special cases, flush, reset).
module tb_complex_integer_divider_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqIsSigned = 1'b0;
  logic        reqIsRem = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [5:0]  reqAlPtr = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        finished;
  logic [31:0] result;
  logic [5:0]  resAlPtr;
  logic        ack = 1'b0;

  int errs = 0;
  int checks = 0;

  complex_integer_divider_unit #(
    .DATA_WIDTH(32),
    .AL_PTR_WIDTH(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqIsSigned(reqIsSigned),
    .reqIsRem(reqIsRem),
    .dividend(dividend),
    .divisor(divisor),
    .reqAlPtr(reqAlPtr),
    .flush(flush),
    .busy(busy),
    .finished(finished),
    .result(result),
    .resAlPtr(resAlPtr),
    .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic s, input logic r,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input logic [5:0] p);
    reqValid    = 1'b1;
    reqIsSigned = s;
    reqIsRem    = r;
    dividend    = a;
    divisor     = b;
    reqAlPtr    = p;
  endtask

  // Issue in the current cycle t, run to cycle t+lat and
  // return what was seen; early flags finished before t+lat.
  task automatic do_op(input logic s, input logic r,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [5:0] p,
                       input int lat,
                       output logic early,
                       output logic fin,
                       output logic [31:0] res,
                       output logic [5:0] rp);
    drive_req(s, r, a, b, p);
    step();
    reqValid = 1'b0;
    early = 1'b0;
    for (int i = 1; i < lat; i++) begin
      if (finished) early = 1'b1;
      step();
    end
    fin = finished;
    res = result;
    rp  = resAlPtr;
  endtask

  task automatic ack_it();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL rst_busy got=%0b want=0", busy);
    end
    checks++;
    if (finished !== 1'b0) begin
      errs++; $display("FAIL rst_fin got=%0b want=0", finished);
    end
    checks++;
    if (result !== 32'h0) begin
      errs++; $display("FAIL rst_res got=%h want=0", result);
    end
    checks++;
    if (resAlPtr !== 6'h0) begin
      errs++; $display("FAIL rst_ptr got=%h want=0", resAlPtr);
    end
    checks++;
    if (reqReady !== 1'b1) begin
      errs++; $display("FAIL rst_rdy got=%0b want=1", reqReady);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    logic e, f;
    logic [31:0] r;
    logic [5:0] p;
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 6'h2A, 33, e, f, r, p);
    checks++;
    if (e !== 1'b0) begin
      errs++; $display("FAIL u_early got=%0b want=0", e);
    end
    checks++;
    if (f !== 1'b1) begin
      errs++; $display("FAIL u_fin33 got=%0b want=1", f);
    end
    checks++;
    if (r !== 32'd14) begin
      errs++; $display("FAIL u_res got=%0d want=14", r);
    end
    checks++;
    if (p !== 6'h2A) begin
      errs++; $display("FAIL u_ptr got=%h want=2a", p);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (finished !== 1'b1 || result !== 32'd14) begin
        errs++;
        $display("FAIL u_hold%0d fin=%0b res=%0d want 1/14",
                 i, finished, result);
      end
    end
    ack_it();
    checks++;
    if (finished !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL u_ack fin=%0b busy=%0b want 0/0",
               finished, busy);
    end
  endtask

  task automatic test_signed();
    logic        sv [3] = '{1'b1, 1'b1, 1'b0};
    logic        rv [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] av [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9,
                            32'hFFFFFFFF};
    logic [31:0] bv [3] = '{32'd2, 32'd2, 32'd2};
    logic [31:0] xv [3] = '{32'hFFFFFFFF, 32'hFFFFFFFD,
                            32'h7FFFFFFF};
    logic e, f;
    logic [31:0] r;
    logic [5:0] p;
    for (int i = 0; i < 3; i++) begin
      do_op(sv[i], rv[i], av[i], bv[i], 6'(i + 3), 33,
            e, f, r, p);
      checks++;
      if (e !== 1'b0 || f !== 1'b1 || r !== xv[i]) begin
        errs++;
        $display("FAIL sgn%0d early=%0b fin=%0b res=%h want 0/1/%h",
                 i, e, f, r, xv[i]);
      end
      ack_it();
    end
  endtask

  task automatic test_special();
    logic        sv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        rv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] av [4] = '{32'd5, 32'd5, 32'h80000000,
                            32'h80000000};
    logic [31:0] bv [4] = '{32'd0, 32'd0, 32'hFFFFFFFF,
                            32'hFFFFFFFF};
    logic [31:0] xv [4] = '{32'hFFFFFFFF, 32'd5,
                            32'h80000000, 32'd0};
    logic e, f;
    logic [31:0] r;
    logic [5:0] p;
    for (int i = 0; i < 4; i++) begin
      do_op(sv[i], rv[i], av[i], bv[i], 6'(i + 9), 1,
            e, f, r, p);
      checks++;
      if (f !== 1'b1 || r !== xv[i] || p !== 6'(i + 9)) begin
        errs++;
        $display("FAIL spc%0d fin=%0b res=%h ptr=%h want 1/%h/%h",
                 i, f, r, p, xv[i], 6'(i + 9));
      end
      ack_it();
    end
  endtask

  task automatic test_flush();
    logic e, f;
    logic [31:0] r;
    logic [5:0] p;
    drive_req(1'b0, 1'b0, 32'd1000, 32'd3, 6'h11);
    step();
    reqValid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || finished !== 1'b0 ||
        reqReady !== 1'b1) begin
      errs++;
      $display("FAIL fl_idle busy=%0b fin=%0b rdy=%0b want 0/0/1",
               busy, finished, reqReady);
    end
    do_op(1'b0, 1'b0, 32'd9, 32'd3, 6'h22, 33, e, f, r, p);
    checks++;
    if (e !== 1'b0) begin
      errs++; $display("FAIL fl_ghost got=%0b want=0", e);
    end
    checks++;
    if (f !== 1'b1 || r !== 32'd3 || p !== 6'h22) begin
      errs++;
      $display("FAIL fl_new fin=%0b res=%0d ptr=%h want 1/3/22",
               f, r, p);
    end
    ack_it();
  endtask

  task automatic test_flush_done();
    logic e, f;
    logic [31:0] r;
    logic [5:0] p;
    do_op(1'b0, 1'b0, 32'd5, 32'd0, 6'h05, 1, e, f, r, p);
    checks++;
    if (f !== 1'b1) begin
      errs++; $display("FAIL fd_setup got=%0b want=1", f);
    end
    drive_req(1'b0, 1'b0, 32'd7, 32'd0, 6'h07);
    ack = 1'b1;
    flush = 1'b1;
    step();
    reqValid = 1'b0;
    ack = 1'b0;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || finished !== 1'b0) begin
      errs++;
      $display("FAIL fd_idle busy=%0b fin=%0b want 0/0",
               busy, finished);
    end
    step();
    checks++;
    if (finished !== 1'b0) begin
      errs++; $display("FAIL fd_stay got=%0b want=0", finished);
    end
  endtask

  task automatic test_back_to_back();
    logic e, f;
    logic [31:0] r;
    logic [5:0] p;
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 6'h01, 33, e, f, r, p);
    drive_req(1'b0, 1'b0, 32'd200, 32'd10, 6'h02);
    ack = 1'b1;
    #0;
    checks++;
    if (reqReady !== 1'b1) begin
      errs++; $display("FAIL b2b_rdy got=%0b want=1", reqReady);
    end
    step();
    reqValid = 1'b0;
    ack = 1'b0;
    e = 1'b0;
    for (int i = 1; i < 33; i++) begin
      if (finished || !busy) e = 1'b1;
      step();
    end
    checks++;
    if (e !== 1'b0) begin
      errs++; $display("FAIL b2b_calc got=%0b want=0", e);
    end
    checks++;
    if (finished !== 1'b1 || result !== 32'd20 ||
        resAlPtr !== 6'h02) begin
      errs++;
      $display("FAIL b2b_res fin=%0b res=%0d ptr=%h want 1/20/02",
               finished, result, resAlPtr);
    end
    ack_it();
  endtask

  task automatic test_async_reset();
    logic e, f;
    logic [31:0] r;
    logic [5:0] p;
    drive_req(1'b0, 1'b0, 32'd1000, 32'd3, 6'h15);
    step();
    reqValid = 1'b0;
    repeat (5) step();
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || finished !== 1'b0 ||
        result !== 32'h0 || resAlPtr !== 6'h0) begin
      errs++;
      $display("FAIL arst busy=%0b fin=%0b res=%h ptr=%h want 0",
               busy, finished, result, resAlPtr);
    end
    repeat (2) step();
    rst = 1'b0;
    step();
    do_op(1'b0, 1'b0, 32'd1, 32'd1, 6'h3F, 33, e, f, r, p);
    checks++;
    if (e !== 1'b0 || f !== 1'b1 || r !== 32'd1) begin
      errs++;
      $display("FAIL arst_op early=%0b fin=%0b res=%0d want 0/1/1",
               e, f, r);
    end
    ack_it();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_flush_done();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
